// File: rtl/vend_transaction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_transaction_sequencer
// Purpose  : Vending transaction controller. Accumulates coins, grants item
//            selections against the running total, runs the inactivity
//            timeout and pays out change greedily, one coin per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vend_transaction_sequencer #(
    parameter int          kNumCoins   = 3,
    parameter int          kNumItems   = 4,
    parameter int          kTotalBits  = 31,
    parameter int          kWaitTime   = 10,
    parameter int unsigned COIN_VAL0   = 100,
    parameter int unsigned COIN_VAL1   = 500,
    parameter int unsigned COIN_VAL2   = 1000,
    parameter int unsigned ITEM_PRICE0 = 400,
    parameter int unsigned ITEM_PRICE1 = 500,
    parameter int unsigned ITEM_PRICE2 = 1000,
    parameter int unsigned ITEM_PRICE3 = 2000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [kNumCoins-1:0]  i_input_coin,
    input  logic [kNumItems-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    output logic [kNumItems-1:0]  o_available_item,
    output logic [kNumItems-1:0]  o_output_item,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic [kTotalBits-1:0] o_current_total,
    output logic                  o_busy
);

    // Two guard bits let the coin sum be compared against the register limit.
    localparam int c_SUM_BITS  = kTotalBits + 2;
    localparam int c_WAIT_BITS = $clog2(kWaitTime + 1);

    localparam logic [kTotalBits-1:0] c_COIN_VAL [kNumCoins] = '{
        kTotalBits'(COIN_VAL0), kTotalBits'(COIN_VAL1), kTotalBits'(COIN_VAL2)
    };
    localparam logic [kTotalBits-1:0] c_ITEM_PRICE [kNumItems] = '{
        kTotalBits'(ITEM_PRICE0), kTotalBits'(ITEM_PRICE1),
        kTotalBits'(ITEM_PRICE2), kTotalBits'(ITEM_PRICE3)
    };
    localparam logic [c_SUM_BITS-1:0]  c_TOTAL_MAX   = {2'b00, {kTotalBits{1'b1}}};
    localparam logic [c_WAIT_BITS-1:0] c_WAIT_RELOAD = c_WAIT_BITS'(kWaitTime);
    localparam logic [c_WAIT_BITS-1:0] c_WAIT_ONE    = c_WAIT_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_RETURN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [kTotalBits-1:0]  r_total;
    logic [kTotalBits-1:0]  w_total_nxt;
    logic [c_WAIT_BITS-1:0] r_wait_cnt;
    logic [c_WAIT_BITS-1:0] w_wait_nxt;
    logic [kNumItems-1:0]   w_item_nxt;
    logic [kNumCoins-1:0]   w_coin_nxt;

    logic [c_SUM_BITS-1:0]  w_coin_sum;
    logic [c_SUM_BITS-1:0]  w_sum_ext;
    logic                   w_coin_ok;
    logic [kTotalBits-1:0]  w_after_coin;
    logic                   w_grant_valid;
    logic [kNumItems-1:0]   w_grant_onehot;
    logic [kTotalBits-1:0]  w_grant_price;
    logic                   w_pay_valid;
    logic [kNumCoins-1:0]   w_pay_onehot;
    logic [kTotalBits-1:0]  w_pay_val;

    // Decode: coin sum with overflow guard, lowest affordable select, largest payable coin.
    always_comb begin
        w_coin_sum     = '0;
        w_grant_valid  = 1'b0;
        w_grant_onehot = '0;
        w_grant_price  = '0;
        w_pay_valid    = 1'b0;
        w_pay_onehot   = '0;
        w_pay_val      = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (i_input_coin[i]) begin
                w_coin_sum = w_coin_sum + c_SUM_BITS'(c_COIN_VAL[i]);
            end
        end
        // Descending scan so the lowest qualifying index is the last one written.
        for (int i = kNumItems - 1; i >= 0; i--) begin
            if (i_select_item[i] && (r_total >= c_ITEM_PRICE[i])) begin
                w_grant_valid     = 1'b1;
                w_grant_onehot    = '0;
                w_grant_onehot[i] = 1'b1;
                w_grant_price     = c_ITEM_PRICE[i];
            end
        end
        // Ascending scan over ascending coin values leaves the largest payable coin.
        for (int i = 0; i < kNumCoins; i++) begin
            if (r_total >= c_COIN_VAL[i]) begin
                w_pay_valid     = 1'b1;
                w_pay_onehot    = '0;
                w_pay_onehot[i] = 1'b1;
                w_pay_val       = c_COIN_VAL[i];
            end
        end
        w_sum_ext    = {2'b00, r_total} + w_coin_sum;
        w_coin_ok    = (|i_input_coin) && (w_sum_ext <= c_TOTAL_MAX);
        w_after_coin = w_coin_ok ? w_sum_ext[kTotalBits-1:0] : r_total;
    end

    // Next-state, next-total, timer and pulse generation.
    always_comb begin
        w_state_nxt = r_state;
        w_total_nxt = r_total;
        w_wait_nxt  = r_wait_cnt;
        w_item_nxt  = '0;
        w_coin_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                w_wait_nxt = '0;
                if (w_coin_ok) begin
                    w_total_nxt = w_after_coin;
                    w_wait_nxt  = c_WAIT_RELOAD;
                    w_state_nxt = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (i_trigger_return || (r_wait_cnt == '0)) begin
                    // Coins still count; a reload here does not cancel the exit.
                    w_total_nxt = w_after_coin;
                    w_wait_nxt  = '0;
                    w_state_nxt = S_RETURN;
                end else begin
                    if (w_grant_valid) begin
                        w_total_nxt = w_after_coin - w_grant_price;
                        w_item_nxt  = w_grant_onehot;
                        w_wait_nxt  = c_WAIT_RELOAD;
                    end else if (w_coin_ok) begin
                        w_total_nxt = w_after_coin;
                        w_wait_nxt  = c_WAIT_RELOAD;
                    end else begin
                        w_wait_nxt  = r_wait_cnt - c_WAIT_ONE;
                    end
                    // A purchase that spends the exact credit ends the transaction.
                    if (w_total_nxt == '0) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RETURN: begin
                w_wait_nxt = '0;
                if (r_total == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pay_valid) begin
                    w_coin_nxt  = w_pay_onehot;
                    w_total_nxt = r_total - w_pay_val;
                end else begin
                    // Residual smaller than the smallest coin is forfeited silently.
                    w_total_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_total_nxt = '0;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // State and registered outputs; asynchronous clear aborts any payout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_total       <= '0;
            r_wait_cnt    <= '0;
            o_output_item <= '0;
            o_return_coin <= '0;
            o_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_total       <= w_total_nxt;
            r_wait_cnt    <= w_wait_nxt;
            o_output_item <= w_item_nxt;
            o_return_coin <= w_coin_nxt;
            o_busy        <= (w_state_nxt == S_RETURN);
        end
    end

    // Availability follows the live total but is masked during payout.
    always_comb begin
        o_available_item = '0;
        for (int i = 0; i < kNumItems; i++) begin
            o_available_item[i] = (r_total >= c_ITEM_PRICE[i]) && (r_state != S_RETURN);
        end
    end

    assign o_current_total = r_total;

endmodule
`default_nettype wire

// File: tb/tb_vend_transaction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_transaction_sequencer
// Purpose  : Directed bench for vend_transaction_sequencer with a pulse
//            scoreboard (expected dispense/change pulses queued by stimulus,
//            popped by a negedge monitor).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_transaction_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  coin;
    logic [3:0]  sel;
    logic        trig;
    logic [3:0]  avail;
    logic [3:0]  item;
    logic [2:0]  ret;
    logic [30:0] total;
    logic        busy;

    typedef struct {
        logic [3:0]  item;
        logic [2:0]  coin;
        logic [30:0] total;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    vend_transaction_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (coin),
        .i_select_item    (sel),
        .i_trigger_return (trig),
        .o_available_item (avail),
        .o_output_item    (item),
        .o_return_coin    (ret),
        .o_current_total  (total),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] it, input logic [2:0] cn, input logic [30:0] tot);
        exp_t e;
        e.item  = it;
        e.coin  = cn;
        e.total = tot;
        q.push_back(e);
    endtask

    // Monitor: every dispense or change pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && ((item != 4'b0) || (ret != 3'b0))) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: actual item=%b coin=%b total=%0d required no pulse",
                         item, ret, total);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ((item !== e.item) || (ret !== e.coin) || (total !== e.total)) begin
                    errors++;
                    $display("FAIL pulse: actual item=%b coin=%b total=%0d required item=%b coin=%b total=%0d",
                             item, ret, total, e.item, e.coin, e.total);
                end
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0;
        coin    = 3'b0;
        sel     = 4'b0;
        trig    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("reset_total", 32'(total), 0);
        check("reset_busy",  32'(busy),  0);
        check("reset_avail", 32'(avail), 0);
        check("reset_pulses", 32'({item, ret}), 0);

        // Two coins in one cycle
        coin = 3'b110;
        tick();
        coin = 3'b000;
        check("coin_sum_total", 32'(total), 1500);
        check("coin_sum_avail", 32'(avail), 32'b0111);

        // Multi-select: lowest affordable wins
        sel = 4'b0110;
        push(4'b0010, 3'b000, 31'd1000);
        tick();
        sel = 4'b0000;
        check("grant_total", 32'(total), 1000);
        tick();
        check("grant_pulse_len", 32'(item), 0);

        // Unaffordable select is dropped
        sel = 4'b1000;
        tick();
        sel = 4'b0000;
        check("unafford_total", 32'(total), 1000);
        check("unafford_item",  32'(item),  0);

        // Build 1600 then request return
        coin = 3'b011;
        tick();
        coin = 3'b000;
        check("total_1600", 32'(total), 1600);
        trig = 1'b1;
        push(4'b0000, 3'b100, 31'd600);
        push(4'b0000, 3'b010, 31'd100);
        push(4'b0000, 3'b001, 31'd0);
        tick();
        trig = 1'b0;
        check("return_avail_masked", 32'(avail), 0);
        n = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            n++;
            tick();
        end
        check("return_busy_cycles", 32'(n), 4);
        check("return_total", 32'(total), 0);

        // Timeout from a single 500 coin
        coin = 3'b010;
        tick();
        coin = 3'b000;
        push(4'b0000, 3'b010, 31'd0);
        n = 0;
        for (int k = 0; k < 30 && !busy; k++) begin
            n++;
            tick();
        end
        check("timeout_cycles", 32'(n), 11);
        for (int k = 0; k < 10 && busy; k++) tick();
        check("timeout_idle", 32'(busy), 0);

        // Coin at cycle 5 restarts the timer
        coin = 3'b010;
        tick();
        coin = 3'b000;
        repeat (4) tick();
        coin = 3'b001;
        tick();
        coin = 3'b000;
        check("reload_total", 32'(total), 600);
        push(4'b0000, 3'b010, 31'd100);
        push(4'b0000, 3'b001, 31'd0);
        n = 0;
        for (int k = 0; k < 30 && !busy; k++) begin
            n++;
            tick();
        end
        check("reload_timeout_cycles", 32'(n), 11);
        for (int k = 0; k < 10 && busy; k++) tick();

        // Select and coin in the same cycle at total=400
        coin = 3'b001;
        repeat (4) tick();
        coin = 3'b000;
        check("total_400", 32'(total), 400);
        sel  = 4'b0001;
        coin = 3'b010;
        push(4'b0001, 3'b000, 31'd500);
        tick();
        sel  = 4'b0000;
        coin = 3'b000;
        check("sel_coin_total", 32'(total), 500);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("ret2_busy", 32'(busy), 1);
        // Coin during payout is ignored
        coin = 3'b100;
        push(4'b0000, 3'b010, 31'd0);
        tick();
        coin = 3'b000;
        check("ret_coin_ignored", 32'(total), 0);
        tick();
        check("ret2_exit", 32'(busy), 0);

        // Asynchronous reset in the middle of a payout
        coin = 3'b110;
        tick();
        coin = 3'b000;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        push(4'b0000, 3'b100, 31'd500);
        tick();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_total", 32'(total), 0);
        check("async_rst_busy",  32'(busy),  0);
        check("async_rst_pulses", 32'({item, ret}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_total", 32'(total), 0);
        check("post_rst_busy",  32'(busy),  0);

        for (int k = 0; k < 50 && q.size() != 0; k++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual pending=%0d required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
